// File: rtl/top_mod_pkg.sv
// Shared types and default sizes for the in-place RAM sorter (top_mod).
package top_mod_pkg;

  localparam int N_DEF = 8;
  localparam int K_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_I = 3'd1,
    LOAD_J = 3'd2,
    CMP    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/top_mod_datapath.sv
// Sorter datapath: k x N RAM, A/B operand registers, i/j indices and comparator.
// Debug read port is enabled by defining TOP_MOD_DEBUG_READ_EN.
module top_mod_datapath
  import top_mod_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int k = K_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  state_t               state,
  input  logic                 s,
  input  logic                 wrinit,
  input  logic [N-1:0]         din,
  input  logic [$clog2(k)-1:0] radd,
  input  logic                 rd,
  output logic [N-1:0]         dout,
  output logic                 i_last,
  output logic                 j_last
);

  localparam int AW = $clog2(k);
  localparam logic [AW-1:0] I_END = AW'(k - 2);
  localparam logic [AW-1:0] J_END = AW'(k - 1);

  logic [N-1:0]  RAM [k];
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic [AW-1:0] i;
  logic [AW-1:0] j;
  logic          b_lt_a;

  assign b_lt_a = (b < a);
  assign i_last = (i == I_END);
  assign j_last = (j == J_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < k; m++) RAM[m] <= '0;
      a <= '0;
      b <= '0;
      i <= '0;
      j <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wrinit) RAM[radd] <= din;
          if (s) i <= '0;
        end
        LOAD_I: begin
          a <= RAM[i];
          j <= i + 1'b1;
        end
        LOAD_J: b <= RAM[j];
        CMP: begin
          // A tracks the running minimum for slot i, so later compares see the swapped value
          if (b_lt_a) begin
            RAM[i] <= b;
            RAM[j] <= a;
            a      <= b;
          end
          if (!j_last)      j <= j + 1'b1;
          else if (!i_last) i <= i + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef TOP_MOD_DEBUG_READ_EN
  assign dout = rd ? RAM[radd] : '0;
`else
  logic unused_rd;
  assign unused_rd = rd;
  assign dout      = '0;
`endif

endmodule

// File: rtl/top_mod.sv
// In-place ascending selection-exchange sorter over a k x N RAM; FSM lives here.
// Optional debug read port: define TOP_MOD_DEBUG_READ_EN.
module top_mod
  import top_mod_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int k = K_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s,
  input  logic [N-1:0]         DataIn,
  input  logic [$clog2(k)-1:0] RAdd,
  input  logic                 Wrinit,
  input  logic                 Rd,
  output logic                 done,
  output logic [N-1:0]         DataOut
);

  state_t state;
  logic   i_last;
  logic   j_last;

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (s) state <= LOAD_I;
        LOAD_I: state <= LOAD_J;
        LOAD_J: state <= CMP;
        CMP: begin
          if (!j_last)      state <= LOAD_J;
          else if (!i_last) state <= LOAD_I;
          else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!s) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  top_mod_datapath #(.N(N), .k(k)) datapath (
    .clk    (clk),
    .rst    (rst_n),
    .state  (state),
    .s      (s),
    .wrinit (Wrinit),
    .din    (DataIn),
    .radd   (RAdd),
    .rd     (Rd),
    .dout   (DataOut),
    .i_last (i_last),
    .j_last (j_last)
  );

endmodule

// File: tb/tb_top_mod.sv
// Scoreboard bench for top_mod: sort jobs push expected RAM image and latency, a monitor checks on done.
module tb_top_mod;
  import top_mod_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s;
  logic [7:0] DataIn;
  logic [2:0] RAdd;
  logic       Wrinit;
  logic       Rd;
  logic       done;
  logic [7:0] DataOut;

  always #5 clk = ~clk;

  top_mod #(.N(8), .k(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s),
    .DataIn  (DataIn),
    .RAdd    (RAdd),
    .Wrinit  (Wrinit),
    .Rd      (Rd),
    .done    (done),
    .DataOut (DataOut)
  );

  typedef struct {
    logic [63:0] words;
    int          start;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of done must match the oldest queued sort job
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sort_latency", 32'(cyc - e.start), 32'(e.lat));
        for (int m = 0; m < 8; m++)
          check($sformatf("ram[%0d]", m), 32'(dut.datapath.RAM[m]), 32'(e.words[m*8 +: 8]));
      end
    end
    done_prev = done;
  end

  task automatic load(input logic [63:0] w);
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      Wrinit = 1'b1;
      RAdd   = 3'(m);
      DataIn = w[m*8 +: 8];
    end
    @(negedge clk);
    Wrinit = 1'b0;
  endtask

  task automatic start_sort(input logic [63:0] expected, input bit track);
    @(negedge clk);
    s = 1'b1;
    if (track) q.push_back('{words: expected, start: cyc, lat: 64});
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; s = 1'b0; DataIn = '0; RAdd = '0; Wrinit = 1'b0; Rd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    // Reset state
    Rd = 1'b1;
    #1;
    check("reset_done", 32'(done), 32'd0);
    check("reset_dataout", 32'(DataOut), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    for (int m = 0; m < 8; m++) check("reset_ram", 32'(dut.datapath.RAM[m]), 32'd0);
    Rd = 1'b0;

    // Mixed data with duplicates and extremes, then hold s after done
    load(64'h00FF030A010F0307);
    start_sort(64'hFF0F0A0703030100, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    check("done_held", 32'(done), 32'd1);
    s = 1'b0;
    @(negedge clk);
    check("done_drop", 32'(done), 32'd0);

    // Already sorted, with Wrinit pulsed during the sort
    load(64'h0706050403020100);
    start_sort(64'h0706050403020100, 1'b1);
    repeat (10) @(negedge clk);
    Wrinit = 1'b1; RAdd = 3'd3; DataIn = 8'hAA;
    repeat (5) @(negedge clk);
    RAdd = 3'd0; DataIn = 8'h55;
    wait_done();
    Wrinit = 1'b0;
    @(negedge clk);
    s = 1'b0;
    @(negedge clk);

    // Reverse sorted, s released early in the sort
    load(64'h0001020304050607);
    start_sort(64'h0706050403020100, 1'b1);
    repeat (3) @(negedge clk);
    s = 1'b0;
    wait_done();
    @(negedge clk);
    check("idle_after_done", 32'(dut.state), 32'(IDLE));
    Rd = 1'b1; RAdd = 3'd7;
    #1;
`ifdef TOP_MOD_DEBUG_READ_EN
    check("debug_read_rd1", 32'(DataOut), 32'h07);
`else
    check("debug_read_rd1", 32'(DataOut), 32'h00);
`endif
    Rd = 1'b0;
    #1;
    check("debug_read_rd0", 32'(DataOut), 32'h00);

    // Reset at sort cycle 20
    load(64'h00FF030A010F0307);
    start_sort(64'h0, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1; s = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    check("midsort_rst_done", 32'(done), 32'd0);
    check("midsort_rst_state", 32'(dut.state), 32'(IDLE));
    for (int m = 0; m < 8; m++) check("midsort_rst_ram", 32'(dut.datapath.RAM[m]), 32'd0);
    repeat (70) @(negedge clk);
    check("midsort_rst_no_done", 32'(done), 32'd0);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
